// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM/divider path and its period meter.
package pwm_pkg;
    localparam int DIV_W = 16;

    typedef enum logic [1:0] {
        ACQUIRE   = 2'd0,
        MEAS_HIGH = 2'd1,
        MEAS_LOW  = 2'd2
    } meas_state_e;
endpackage

// File: rtl/clock_period_meter_if.sv
// Measured-clock input and result bus of the period meter.
interface clock_period_meter_if #(parameter int CNT_W = 17);
    logic                         i_meas_clk;
    logic [CNT_W-1:0]             o_high_cnt;
    logic [CNT_W-1:0]             o_low_cnt;
    logic [pwm_pkg::DIV_W-1:0]    o_divisor;
    logic                         o_symmetric;
    logic                         o_valid;
    logic                         o_locked;
    logic                         o_stalled;

    modport master (
        output i_meas_clk,
        input  o_high_cnt, o_low_cnt, o_divisor, o_symmetric, o_valid, o_locked, o_stalled
    );
    modport slave (
        input  i_meas_clk,
        output o_high_cnt, o_low_cnt, o_divisor, o_symmetric, o_valid, o_locked, o_stalled
    );
endinterface

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer with a history flop producing single-cycle edge strobes.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = o_level & ~r_hist;
    assign o_fall  = ~o_level & r_hist;
endmodule

// File: rtl/clock_period_meter.sv
// Measures high/low phase lengths of a slow clock in i_clk cycles, recovers the
// divisor and reports symmetry, lock and stall status.
module clock_period_meter
    import pwm_pkg::*;
#(
    parameter int CNT_W       = 17,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 131071
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    clock_period_meter_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
    localparam int               XW      = CNT_W + DIV_W;
    localparam logic [DIV_W-1:0] DIV_MAX = '1;

    logic w_rise, w_fall, w_edge, w_unused_level;
    logic w_load, w_hold_high, w_result, w_to_hit;
    meas_state_e r_state, w_state_nxt;

    logic [CNT_W-1:0] r_cnt, r_to, r_high;
    logic [CNT_W-1:0] r_high_cnt, r_low_cnt;
    logic [DIV_W-1:0] r_divisor;
    logic             r_symmetric, r_valid, r_locked, r_stalled, r_have_prev;

    logic [CNT_W:0]   w_sum, w_half;
    logic [XW-1:0]    w_half_ext;
    logic [DIV_W-1:0] w_div;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_async (bus.i_meas_clk),
        .o_level (w_unused_level),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    assign w_edge   = w_rise | w_fall;
    assign w_to_hit = !w_edge && (r_to == TO_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ACQUIRE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_hold_high = 1'b0;
        w_result    = 1'b0;
        unique case (r_state)
            ACQUIRE:   if (w_rise) begin w_state_nxt = MEAS_HIGH; w_load = 1'b1; end
            MEAS_HIGH: if (w_fall) begin w_state_nxt = MEAS_LOW;  w_load = 1'b1; w_hold_high = 1'b1; end
            MEAS_LOW:  if (w_rise) begin w_state_nxt = MEAS_HIGH; w_load = 1'b1; w_result = 1'b1; end
            default:   w_state_nxt = ACQUIRE;
        endcase
        if (w_to_hit) w_state_nxt = ACQUIRE;
    end

    // Sum carries one extra bit so two saturated phases cannot wrap before halving.
    assign w_sum      = {1'b0, r_high} + {1'b0, r_cnt};
    assign w_half     = w_sum >> 1;
    assign w_half_ext = XW'(w_half);
    assign w_div      = (w_half_ext > XW'(DIV_MAX)) ? DIV_MAX : w_half_ext[DIV_W-1:0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt       <= '0;
            r_to        <= '0;
            r_high      <= '0;
            r_high_cnt  <= '0;
            r_low_cnt   <= '0;
            r_divisor   <= '0;
            r_symmetric <= 1'b0;
            r_valid     <= 1'b0;
            r_locked    <= 1'b0;
            r_stalled   <= 1'b0;
            r_have_prev <= 1'b0;
        end else begin
            if (w_load)                r_cnt <= CNT_W'(1);
            else if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;

            if (w_edge)              r_to <= '0;
            else if (r_to != TO_VAL) r_to <= r_to + 1'b1;

            if (w_hold_high) r_high <= r_cnt;

            r_valid <= w_result;
            if (w_result) begin
                r_high_cnt  <= r_high;
                r_low_cnt   <= r_cnt;
                r_divisor   <= w_div;
                r_symmetric <= (r_high == r_cnt);
                r_locked    <= r_have_prev && (r_high == r_high_cnt) && (r_cnt == r_low_cnt);
                r_have_prev <= 1'b1;
            end

            // Results stay on display across a stall; only the lock history is dropped.
            if (w_to_hit) begin
                r_stalled   <= 1'b1;
                r_locked    <= 1'b0;
                r_have_prev <= 1'b0;
            end else if (w_rise) begin
                r_stalled   <= 1'b0;
            end
        end
    end

    assign bus.o_high_cnt  = r_high_cnt;
    assign bus.o_low_cnt   = r_low_cnt;
    assign bus.o_divisor   = r_divisor;
    assign bus.o_symmetric = r_symmetric;
    assign bus.o_valid     = r_valid;
    assign bus.o_locked    = r_locked;
    assign bus.o_stalled   = r_stalled;
endmodule
